// File: rtl/bean_pkg.sv
// Shared BEAN-1 encodings: opcodes, control FSM states and datapath/memory select codes.
// Used by control_unit (build option CONTROL_ILLEGAL_TRAP_EN), datapath and mem.
package bean_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_I    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] REG_SEL_MEM = 2'b00;
    localparam logic [1:0] REG_SEL_ALU = 2'b01;
    localparam logic [1:0] REG_SEL_PC4 = 2'b10;
    localparam logic [1:0] REG_SEL_IMM = 2'b11;

    localparam logic [1:0] PC_SEL_PC4     = 2'b00;
    localparam logic [1:0] PC_SEL_ALU     = 2'b01;
    localparam logic [1:0] PC_SEL_ALU_ALN = 2'b10;

    localparam logic [2:0] MEM_WORD   = 3'b000;
    localparam logic [2:0] MEM_HALF   = 3'b001;
    localparam logic [2:0] MEM_BYTE   = 3'b010;
    localparam logic [2:0] MEM_HALF_U = 3'b101;
    localparam logic [2:0] MEM_BYTE_U = 3'b110;

    typedef struct packed {
        logic       reg_we;
        logic       rs1_sel;
        logic       rs2_sel;
        logic [1:0] reg_sel;
        logic [1:0] pc_sel;
        logic [2:0] imm_sel;
        logic [3:0] alu_mode;
        logic       addrs_sel;
        logic       pc_en;
        logic       instr_en;
        logic       alu_mem_en;
        logic       mem_in_en;
        logic       mem_we;
        logic [2:0] mem_mode;
        logic       halted;
    } ctl_t;

    // Load/store funct3 to access size; unused codes fall back to word.
    function automatic logic [2:0] mem_mode_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return MEM_BYTE;
            3'b001:  return MEM_HALF;
            3'b100:  return MEM_BYTE_U;
            3'b101:  return MEM_HALF_U;
            default: return MEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for OP / OP-IMM, plus a funct3/funct7 legality flag.
// Every other opcode uses the adder (address / PC-relative arithmetic).
module alu_decoder
    import bean_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alu_mode,
    output logic       o_legal
);

    logic w_is_op;
    logic w_is_imm;
    logic w_f7_zero;
    logic w_f7_alt;

    assign w_is_op   = (i_opcode == OPC_OP);
    assign w_is_imm  = (i_opcode == OPC_OP_IMM);
    assign w_f7_zero = (i_funct7 == 7'b0000000);
    assign w_f7_alt  = (i_funct7 == 7'b0100000);

    always_comb begin
        o_alu_mode = ALU_ADD;
        o_legal    = 1'b1;
        if (w_is_op || w_is_imm) begin
            case (i_funct3)
                3'b000:  o_alu_mode = (w_is_op && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  o_alu_mode = ALU_SLL;
                3'b010:  o_alu_mode = ALU_SLT;
                3'b011:  o_alu_mode = ALU_SLTU;
                3'b100:  o_alu_mode = ALU_XOR;
                3'b101:  o_alu_mode = i_funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  o_alu_mode = ALU_OR;
                default: o_alu_mode = ALU_AND;
            endcase
            // OP-IMM upper bits are immediate except for the shift encodings.
            if (w_is_op) begin
                o_legal = w_f7_zero ||
                          (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101));
            end else if (i_funct3 == 3'b001) begin
                o_legal = w_f7_zero;
            end else if (i_funct3 == 3'b101) begin
                o_legal = w_f7_zero || w_f7_alt;
            end
        end
    end

endmodule

// File: rtl/control_unit.sv
// BEAN-1 multi-cycle control FSM: FETCH -> EXECUTE (-> WRITEBACK for loads), HALT on SYSTEM.
// Build option CONTROL_ILLEGAL_TRAP_EN: illegal encodings halt instead of executing as NOP.
module control_unit
    import bean_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output logic        reg_WE,
    output logic        rs1_SEL,
    output logic        rs2_SEL,
    output logic [1:0]  reg_SEL,
    output logic [1:0]  pc_SEL,
    output logic [2:0]  imm_SEL,
    output logic [3:0]  ALU_MODE,
    output logic        addrs_SEL,
    output logic        pc_EN,
    output logic        instr_EN,
    output logic        ALU_mem_EN,
    output logic        mem_in_EN,
    output logic        mem_WE,
    output logic [2:0]  mem_MODE,
    output logic        halted
);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_ld_mode;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [3:0] w_alu_mode;
    logic       w_alu_legal;
    logic       w_legal;
    logic       w_taken;
    logic [2:0] w_mem_mode;
    logic       w_unused;
    ctl_t       w_ctl;
    ctl_t       w_out;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];
    assign w_funct7   = instr[31:25];
    assign w_mem_mode = mem_mode_from_funct3(w_funct3);
    assign w_unused   = ^{instr[24:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .i_opcode   (w_opcode),
        .i_funct3   (w_funct3),
        .i_funct7   (w_funct7),
        .o_alu_mode (w_alu_mode),
        .o_legal    (w_alu_legal)
    );

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_OP_IMM: w_legal = w_alu_legal;
            OPC_LOAD:           w_legal = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
            OPC_STORE:          w_legal = (w_funct3 <= 3'b010);
            OPC_BRANCH:         w_legal = (w_funct3[2:1] != 2'b01);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM: w_legal = 1'b1;
            default:            w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = br_eq;
            3'b001:  w_taken = !br_eq;
            3'b100:  w_taken = br_lt;
            3'b101:  w_taken = !br_lt;
            3'b110:  w_taken = br_ltu;
            3'b111:  w_taken = !br_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_FETCH;
            r_ld_mode <= MEM_WORD;
        end else begin
            r_state <= w_state_next;
            // Held for WRITEBACK so a changing instr cannot alter the load size.
            if (r_state == ST_EXECUTE) begin
                r_ld_mode <= w_mem_mode;
            end
        end
    end

    always_comb begin
        w_ctl        = '0;
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                w_ctl.addrs_sel = 1'b1;
                w_ctl.instr_en  = 1'b1;
                w_ctl.mem_in_en = 1'b1;
                w_ctl.mem_mode  = MEM_WORD;
                w_state_next    = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_state_next = ST_FETCH;
                if (w_opcode == OPC_SYSTEM) begin
                    w_state_next = ST_HALT;
                end else if (!w_legal) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    w_state_next = ST_HALT;
`else
                    w_ctl.pc_en = 1'b1;
`endif
                end else begin
                    w_ctl.pc_en = 1'b1;
                    case (w_opcode)
                        OPC_OP, OPC_OP_IMM: begin
                            w_ctl.rs2_sel  = (w_opcode == OPC_OP_IMM);
                            w_ctl.imm_sel  = (w_opcode == OPC_OP_IMM) ? IMM_I : IMM_NONE;
                            w_ctl.alu_mode = w_alu_mode;
                            w_ctl.reg_sel  = REG_SEL_ALU;
                            w_ctl.reg_we   = 1'b1;
                        end
                        OPC_LUI: begin
                            w_ctl.imm_sel = IMM_U;
                            w_ctl.reg_sel = REG_SEL_IMM;
                            w_ctl.reg_we  = 1'b1;
                        end
                        OPC_AUIPC: begin
                            w_ctl.rs1_sel = 1'b1;
                            w_ctl.rs2_sel = 1'b1;
                            w_ctl.imm_sel = IMM_U;
                            w_ctl.reg_sel = REG_SEL_ALU;
                            w_ctl.reg_we  = 1'b1;
                        end
                        OPC_JAL: begin
                            w_ctl.rs1_sel = 1'b1;
                            w_ctl.rs2_sel = 1'b1;
                            w_ctl.imm_sel = IMM_J;
                            w_ctl.pc_sel  = PC_SEL_ALU;
                            w_ctl.reg_sel = REG_SEL_PC4;
                            w_ctl.reg_we  = 1'b1;
                        end
                        OPC_JALR: begin
                            w_ctl.rs2_sel = 1'b1;
                            w_ctl.imm_sel = IMM_I;
                            w_ctl.pc_sel  = PC_SEL_ALU_ALN;
                            w_ctl.reg_sel = REG_SEL_PC4;
                            w_ctl.reg_we  = 1'b1;
                        end
                        OPC_BRANCH: begin
                            w_ctl.rs1_sel = 1'b1;
                            w_ctl.rs2_sel = 1'b1;
                            w_ctl.imm_sel = IMM_B;
                            w_ctl.pc_sel  = w_taken ? PC_SEL_ALU : PC_SEL_PC4;
                        end
                        OPC_STORE: begin
                            w_ctl.rs2_sel    = 1'b1;
                            w_ctl.imm_sel    = IMM_S;
                            w_ctl.alu_mem_en = 1'b1;
                            w_ctl.mem_we     = 1'b1;
                            w_ctl.mem_mode   = w_mem_mode;
                        end
                        OPC_LOAD: begin
                            w_ctl.pc_en      = 1'b0;
                            w_ctl.rs2_sel    = 1'b1;
                            w_ctl.imm_sel    = IMM_I;
                            w_ctl.alu_mem_en = 1'b1;
                            w_ctl.mem_in_en  = 1'b1;
                            w_ctl.mem_mode   = w_mem_mode;
                            w_state_next     = ST_WRITEBACK;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITEBACK: begin
                w_ctl.reg_sel  = REG_SEL_MEM;
                w_ctl.reg_we   = 1'b1;
                w_ctl.pc_en    = 1'b1;
                w_ctl.mem_mode = r_ld_mode;
                w_state_next   = ST_FETCH;
            end
            default: begin
                w_ctl.halted = 1'b1;
                w_state_next = ST_HALT;
            end
        endcase
    end

    // Reset is synchronous, so the state may still be stale while reset is low.
    assign w_out = reset ? w_ctl : '0;

    assign reg_WE     = w_out.reg_we;
    assign rs1_SEL    = w_out.rs1_sel;
    assign rs2_SEL    = w_out.rs2_sel;
    assign reg_SEL    = w_out.reg_sel;
    assign pc_SEL     = w_out.pc_sel;
    assign imm_SEL    = w_out.imm_sel;
    assign ALU_MODE   = w_out.alu_mode;
    assign addrs_SEL  = w_out.addrs_sel;
    assign pc_EN      = w_out.pc_en;
    assign instr_EN   = w_out.instr_en;
    assign ALU_mem_EN = w_out.alu_mem_en;
    assign mem_in_EN  = w_out.mem_in_en;
    assign mem_WE     = w_out.mem_we;
    assign mem_MODE   = w_out.mem_mode;
    assign halted     = w_out.halted;

endmodule
